// File: rtl/param_ram.sv
// param_ram: parametrised bus-attached RAM that owns its own address register.
//   Run mode     : addressed by the bus-loaded address register. Written from the bus on
//                  load and read onto the bus on dataout_en.
//   Program mode : written from the front-panel switches. A 2-flop synchroniser and an edge
//                  detector turn each rising edge of load_manual into exactly one write. The
//                  address comes either from an auto-incrementing pointer or from the address
//                  switches.
//   Optional     : a clear sequencer writes zero to one word per cycle. It is compiled in only
//                  when the macro RAM_CLR_SEQ_EN is defined; otherwise busy_o is tied low and
//                  mem_clr_i is ignored.
// Ports:
//   clk_i, clr_ni        clock; asynchronous active-low reset (memory contents are not reset)
//   program_mode_i       1 = manual programming mode, 0 = run mode
//   addr_in_i/addr_en_i  bus address and its load enable
//   addr_clr_i           synchronous clear of the address register (wins over addr_en_i)
//   load_i, dataout_en_i run-mode write strobe and bus read enable
//   addr_in_manual_i     program-mode address switches
//   data_in_manual_i     program-mode data switches
//   load_manual_i        program-mode write switch (asynchronous level)
//   auto_inc_i           program mode: address from the internal pointer instead of the switches
//   mem_clr_i            request a full memory clear
//   busy_o               clear sequence in progress
//   addr_out_o           address register value
//   data_io              processor bus; high impedance unless the RAM is driving it
module param_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              clr_ni,
  input  logic              program_mode_i,
  input  logic [ADDR_W-1:0] addr_in_i,
  input  logic              addr_en_i,
  input  logic              addr_clr_i,
  input  logic              load_i,
  input  logic              dataout_en_i,
  input  logic [ADDR_W-1:0] addr_in_manual_i,
  input  logic [DATA_W-1:0] data_in_manual_i,
  input  logic              load_manual_i,
  input  logic              auto_inc_i,
  input  logic              mem_clr_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_out_o,
  inout  wire  [DATA_W-1:0] data_io
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] addr_q, prog_ptr_q, sel_addr, clr_ptr;
  logic              pm_q;
  logic              ld_s1_q, ld_s2_q, ld_s3_q;
  logic              busy, clr_we, run_we, prog_we, drive;

  // ld_s1/ld_s2 form the synchroniser and ld_s3 holds the previous synchronised level. The write
  // fires on the third clock edge after the switch rises.
  assign prog_we  = program_mode_i & ld_s2_q & ~ld_s3_q & ~busy;
  assign run_we   = ~program_mode_i & load_i & ~dataout_en_i & ~busy;
  // The bus is also released while reset is asserted.
  assign drive    = dataout_en_i & ~busy & clr_ni;

  always_comb begin
    sel_addr = addr_q;
    if (program_mode_i) sel_addr = auto_inc_i ? prog_ptr_q : addr_in_manual_i;
  end

  assign data_io    = drive ? mem_q[sel_addr] : {DATA_W{1'bz}};
  assign addr_out_o = addr_q;
  assign busy_o     = busy;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      addr_q     <= '0;
      prog_ptr_q <= '0;
      pm_q       <= 1'b0;
      ld_s1_q    <= 1'b0;
      ld_s2_q    <= 1'b0;
      ld_s3_q    <= 1'b0;
    end else begin
      if (addr_clr_i)     addr_q <= '0;
      else if (addr_en_i) addr_q <= addr_in_i;
      ld_s1_q <= load_manual_i;
      ld_s2_q <= ld_s1_q;
      ld_s3_q <= ld_s2_q;
      pm_q    <= program_mode_i;
      // Entering program mode restarts the load pointer. Natural wrap at Depth-1 -> 0.
      if (program_mode_i && !pm_q)     prog_ptr_q <= '0;
      else if (prog_we && auto_inc_i)  prog_ptr_q <= prog_ptr_q + 1'b1;
    end
  end

  // Storage has no reset; contents survive clr_ni.
  always_ff @(posedge clk_i) begin
    if (clr_we)       mem_q[clr_ptr]  <= '0;
    else if (run_we)  mem_q[addr_q]   <= data_io;
    else if (prog_we) mem_q[sel_addr] <= data_in_manual_i;
  end

`ifdef RAM_CLR_SEQ_EN
  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q   <= StIdle;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_clr_i) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign clr_we  = (state_q == StClear);
  assign clr_ptr = clr_ptr_q;
`else
  logic unused_mem_clr;

  assign unused_mem_clr = mem_clr_i;
  assign busy           = 1'b0;
  assign clr_we         = 1'b0;
  assign clr_ptr        = '0;
`endif

endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram (DATA_W=8, ADDR_W=4). A shadow array and a load-pointer
// counter track what the RAM should hold; each operation updates them directly.
module tb_param_ram;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       program_mode = 1'b0, addr_en = 1'b0, addr_clr = 1'b0, load = 1'b0;
  logic       dataout_en = 1'b0, load_manual = 1'b0, auto_inc = 1'b0, mem_clr = 1'b0;
  logic [3:0] addr_in = '0, addr_in_manual = '0;
  logic [7:0] data_in_manual = '0;
  logic       busy;
  logic [3:0] addr_out;
  logic [7:0] bus_drv = '0;
  logic       bus_oe = 1'b0;
  wire  [7:0] data;

  assign data = bus_oe ? bus_drv : 8'hzz;

  param_ram #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_i            (clk),
    .clr_ni           (clr_n),
    .program_mode_i   (program_mode),
    .addr_in_i        (addr_in),
    .addr_en_i        (addr_en),
    .addr_clr_i       (addr_clr),
    .load_i           (load),
    .dataout_en_i     (dataout_en),
    .addr_in_manual_i (addr_in_manual),
    .data_in_manual_i (data_in_manual),
    .load_manual_i    (load_manual),
    .auto_inc_i       (auto_inc),
    .mem_clr_i        (mem_clr),
    .busy_o           (busy),
    .addr_out_o       (addr_out),
    .data_io          (data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_mem [16];
  int         ptr_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus released by the RAM: two opposite probe patterns must read back unchanged.
  task automatic chk_z(input string tag);
    bus_oe = 1'b1; bus_drv = 8'h5a; #1;
    check_eq({tag, "_z5a"}, 32'(data), 32'h5a);
    bus_drv = 8'ha5; #1;
    check_eq({tag, "_za5"}, 32'(data), 32'ha5);
    bus_oe = 1'b0;
  endtask

  task automatic run_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); addr_in = a; addr_en = 1'b1;
    @(negedge clk); addr_en = 1'b0; bus_oe = 1'b1; bus_drv = d; load = 1'b1;
    @(negedge clk); load = 1'b0; bus_oe = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a);
    @(negedge clk); addr_in = a; addr_en = 1'b1;
    @(negedge clk); addr_en = 1'b0; dataout_en = 1'b1; #1;
    check_eq($sformatf("%s_m%0d", tag, a), 32'(data), 32'(model_mem[a]));
    dataout_en = 1'b0;
  endtask

  task automatic enter_prog(input logic ai);
    @(negedge clk); program_mode = 1'b1; auto_inc = ai; ptr_m = 0;
    tick(1);
  endtask

  task automatic prog_pulse(input logic [7:0] d);
    data_in_manual = d; load_manual = 1'b1;
    tick(4);
    load_manual = 1'b0;
    tick(4);
    if (auto_inc) begin
      model_mem[ptr_m] = d;
      ptr_m = (ptr_m + 1) % 16;
    end else begin
      model_mem[addr_in_manual] = d;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         cnt;
    int         guard;
    logic [7:0] d;

    // Reset with random inputs, read enable forced on.
    repeat (4) begin
      @(negedge clk);
      addr_in = 4'($urandom); addr_en = 1'($urandom); load = 1'($urandom);
      mem_clr = 1'($urandom); load_manual = 1'($urandom); program_mode = 1'($urandom);
      dataout_en = 1'b1;
    end
    check_eq("rst_addr", 32'(addr_out), 0);
    check_eq("rst_busy", 32'(busy), 0);
    chk_z("rst_bus");
    @(negedge clk);
    addr_en = 1'b0; load = 1'b0; mem_clr = 1'b0; load_manual = 1'b0; program_mode = 1'b0;
    dataout_en = 1'b0;
    clr_n = 1'b1;
    tick(4);
    chk_z("idle_bus");
    check_eq("post_rst_addr", 32'(addr_out), 0);

    // Known contents, then random run-mode traffic.
    for (int a = 0; a < 16; a++) run_write(4'(a), 8'($urandom) | 8'h01);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) run_write(4'($urandom), 8'($urandom));
      else read_chk("rand", 4'($urandom));
    end

    // addr_clr beats addr_en.
    @(negedge clk); addr_in = 4'hb; addr_en = 1'b1; addr_clr = 1'b1;
    @(negedge clk); addr_en = 1'b0; addr_clr = 1'b0;
    check_eq("addr_clr_wins", 32'(addr_out), 0);

    // Run-mode write/read and load+dataout_en together.
    run_write(4'd5, 8'ha5);
    read_chk("run_a5", 4'd5);
    run_write(4'd5, 8'h3c);
    @(negedge clk); addr_in = 4'd5; addr_en = 1'b1;
    @(negedge clk); addr_en = 1'b0; load = 1'b1; dataout_en = 1'b1; #1;
    check_eq("ld_and_oe_bus", 32'(data), 32'h3c);
    @(negedge clk); load = 1'b0; dataout_en = 1'b0;
    read_chk("ld_and_oe_mem", 4'd5);

    // Program mode with auto-increment; a held switch writes once.
    enter_prog(1'b1);
    prog_pulse(8'h11);
    prog_pulse(8'h22);
    prog_pulse(8'h33);
    data_in_manual = 8'h44; load_manual = 1'b1;
    tick(10);
    data_in_manual = 8'h55;
    tick(3);
    load_manual = 1'b0;
    tick(4);
    model_mem[ptr_m] = 8'h44; ptr_m++;
    prog_pulse(8'h66);
    @(negedge clk); program_mode = 1'b0;
    for (int a = 0; a < 6; a++) read_chk("prog", 4'(a));

    // Pointer wrap, then manual addressing.
    enter_prog(1'b1);
    for (int i = 0; i <= 16; i++) prog_pulse(8'(i));
    @(negedge clk); auto_inc = 1'b0; addr_in_manual = 4'd9;
    prog_pulse(8'($urandom));
    @(negedge clk); program_mode = 1'b0;
    read_chk("wrap", 4'd0);
    read_chk("wrap", 4'd1);
    read_chk("manual", 4'd9);
    read_chk("wrap", 4'd15);

    // Edge discarded when program mode drops before the write lands.
    enter_prog(1'b0);
    addr_in_manual = 4'd7; data_in_manual = ~model_mem[7]; load_manual = 1'b1;
    @(negedge clk); program_mode = 1'b0;
    tick(5);
    load_manual = 1'b0;
    tick(4);
    read_chk("mode_drop", 4'd7);

`ifdef RAM_CLR_SEQ_EN
    // Full clear: busy for exactly 16 cycles, load and read ignored meanwhile.
    @(negedge clk); addr_in = 4'd3; addr_en = 1'b1;
    @(negedge clk); addr_en = 1'b0; mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    cnt = 0; guard = 0;
    while (busy && guard < 40) begin
      cnt++;
      if (cnt == 5) mem_clr = 1'b1;
      if (cnt == 6) mem_clr = 1'b0;
      if (cnt == 15) begin load = 1'b1; bus_oe = 1'b1; bus_drv = 8'hff; end
      if (cnt == 16) begin load = 1'b0; bus_oe = 1'b0; end
      if (cnt == 8) begin dataout_en = 1'b1; chk_z("busy_bus"); dataout_en = 1'b0; end
      @(negedge clk);
      guard++;
    end
    check_eq("busy_cycles", 32'(cnt), 16);
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    for (int a = 0; a < 16; a++) read_chk("cleared", 4'(a));

    // Reset during the sixth clear cycle.
    for (int a = 0; a < 16; a++) run_write(4'(a), 8'($urandom) | 8'h80);
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    tick(5);
    check_eq("busy_mid", 32'(busy), 1);
    clr_n = 1'b0; #1;
    check_eq("busy_abort", 32'(busy), 0);
    for (int a = 0; a < 5; a++) model_mem[a] = 8'h00;
    @(negedge clk); clr_n = 1'b1;
    for (int a = 0; a < 16; a++) read_chk("partial", 4'(a));
`else
    // Without the sequencer mem_clr does nothing.
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check_eq("no_seq_busy", 32'(cnt), 0);
    for (int a = 0; a < 16; a++) read_chk("no_seq_mem", 4'(a));
`endif

    d = 8'($urandom);
    run_write(4'd12, d);
    read_chk("final", 4'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
